// File: rtl/jk_pkg.sv
// Shared constants for JK-cell based blocks: mode encodings and the
// JK action encodings, which are chosen to match the {j,k} pair.
package jk_pkg;

    localparam int MODE_W = 3;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_HOLD = 3'b000;
    localparam mode_t MODE_JK   = 3'b001;
    localparam mode_t MODE_UP   = 3'b010;
    localparam mode_t MODE_DOWN = 3'b011;
    localparam mode_t MODE_LOAD = 3'b100;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_action_e;

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK flip-flop with synchronous active-high reset to a
// per-instance reset value.
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rst_val_i,
    input  logic j_i,
    input  logic k_i,
    output logic q_o
);

    logic state_q;
    logic state_d;

    always_comb begin
        state_d = state_q;
        case (jk_action_e'({j_i, k_i}))
            JK_HOLD:   state_d = state_q;
            JK_RESET:  state_d = 1'b0;
            JK_SET:    state_d = 1'b1;
            JK_TOGGLE: state_d = ~state_q;
            default:   state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= rst_val_i;
        end else begin
            state_q <= state_d;
        end
    end

    assign q_o = state_q;

endmodule

// File: rtl/jk_mode_counter.sv
// WIDTH-bit register of JK cells with raw JK, modulo up/down count, load
// and hold modes, plus terminal-count and sticky overflow status.
module jk_mode_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16,
    parameter int RST_VAL = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  j,
    input  logic [WIDTH-1:0]  k,
    input  logic [WIDTH-1:0]  d,
    input  logic              clr_ovf,
    output logic [WIDTH-1:0]  q,
    output logic              tc,
    output logic              ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] nxt_d;
    logic [WIDTH-1:0] cell_j;
    logic [WIDTH-1:0] cell_k;
    logic             ovf_q;
    logic             ovf_d;

    // Target value for every bit; the JK cells are then steered towards it.
    always_comb begin
        nxt_d = cnt_q;
        if (en) begin
            case (mode)
                MODE_JK:   nxt_d = (cnt_q & ~k) | (~cnt_q & j);
                MODE_UP:   nxt_d = (cnt_q >= MAX_VAL) ? '0 : cnt_q + 1'b1;
                MODE_DOWN: begin
                    if (cnt_q == '0 || cnt_q > MAX_VAL) begin
                        nxt_d = MAX_VAL;
                    end else begin
                        nxt_d = cnt_q - 1'b1;
                    end
                end
                MODE_LOAD: nxt_d = d;
                default:   nxt_d = cnt_q;
            endcase
        end
    end

    assign cell_j = ~cnt_q & nxt_d;
    assign cell_k = cnt_q & ~nxt_d;

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk       (clk),
            .rst       (rst),
            .rst_val_i (RST_Q[g]),
            .j_i       (cell_j[g]),
            .k_i       (cell_k[g]),
            .q_o       (cnt_q[g])
        );
    end

    assign tc = en & (((mode == MODE_UP) & (cnt_q >= MAX_VAL)) |
                      ((mode == MODE_DOWN) & (cnt_q == '0)));

    // A wrap in the same cycle as a clear request keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (tc) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign q   = cnt_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_jk_mode_counter.sv
// Scoreboard bench for jk_mode_counter (WIDTH=4, MODULUS=10); a second
// instance with RST_VAL=5 shares all inputs to check the reset value.
module tb_jk_mode_counter;
    import jk_pkg::*;

    typedef struct {
        string      name;
        logic [3:0] q;
        logic       tc;
        logic       ovf;
        bit         chkR;
        logic [3:0] qR;
    } expect_t;

    logic              clk;
    logic              rst;
    logic              en;
    logic [MODE_W-1:0] mode;
    logic [3:0]        j;
    logic [3:0]        k;
    logic [3:0]        d;
    logic              clr_ovf;
    logic [3:0]        q;
    logic              tc;
    logic              ovf;
    logic [3:0]        qR;
    logic              tcR;
    logic              ovfR;

    expect_t sb[$];
    int      compared   = 0;
    int      mismatched = 0;

    jk_mode_counter #(.WIDTH(4), .MODULUS(10), .RST_VAL(0)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k), .d(d),
        .clr_ovf(clr_ovf), .q(q), .tc(tc), .ovf(ovf)
    );

    jk_mode_counter #(.WIDTH(4), .MODULUS(10), .RST_VAL(5)) dutR (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k), .d(d),
        .clr_ovf(clr_ovf), .q(qR), .tc(tcR), .ovf(ovfR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares one field and keeps the running counts.
    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives one cycle of inputs just after the edge; the expected values
    // describe what the outputs must show in the middle of this cycle.
    task automatic applyStimulus(input string name, input logic r, input logic e,
                                 input mode_t m, input logic [3:0] jv, input logic [3:0] kv,
                                 input logic [3:0] dv, input logic c, input bit chk,
                                 input logic [3:0] eq, input logic etc, input logic eovf,
                                 input bit chkR, input logic [3:0] eqR);
        expect_t x;
        @(posedge clk);
        #1;
        rst = r; en = e; mode = m; j = jv; k = kv; d = dv; clr_ovf = c;
        if (chk) begin
            x.name = name; x.q = eq; x.tc = etc; x.ovf = eovf; x.chkR = chkR; x.qR = eqR;
            sb.push_back(x);
        end
    endtask

    // Monitor: pops the expected response for the current cycle.
    initial begin
        expect_t x;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                checkOutput({x.name, ".q"}, q, x.q);
                checkOutput({x.name, ".tc"}, {3'b0, tc}, {3'b0, x.tc});
                checkOutput({x.name, ".ovf"}, {3'b0, ovf}, {3'b0, x.ovf});
                if (x.chkR) checkOutput({x.name, ".qR"}, qR, x.qR);
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; mode = MODE_HOLD; j = '0; k = '0; d = '0; clr_ovf = 1'b0;

        applyStimulus("rst0", 1, 0, MODE_HOLD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("rst1", 1, 1, MODE_HOLD, 0, 0, 0, 0, 1, 0, 0, 0, 1, 5);
        applyStimulus("rst2", 0, 1, MODE_HOLD, 0, 0, 0, 0, 1, 0, 0, 0, 1, 5);

        applyStimulus("jkld",   0, 1, MODE_LOAD, 0, 0, 4'b1010, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus("jk",     0, 1, MODE_JK, 4'b0011, 4'b0101, 0, 0, 1, 4'b1010, 0, 0, 0, 0);
        applyStimulus("jkres",  0, 1, MODE_HOLD, 0, 0, 0, 0, 1, 4'b1011, 0, 0, 0, 0);

        applyStimulus("upld", 0, 1, MODE_LOAD, 0, 0, 0, 0, 1, 4'd11, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            applyStimulus($sformatf("up%0d", i), 0, 1, MODE_UP, 0, 0, 0, 0, 1,
                          4'(i % 10), (i == 9), (i >= 10), 0, 0);
        end
        applyStimulus("upend", 0, 1, MODE_HOLD, 0, 0, 0, 1, 1, 4'd2, 0, 1, 0, 0);

        applyStimulus("dnld",  0, 1, MODE_LOAD, 0, 0, 4'd13, 0, 1, 4'd2, 0, 0, 0, 0);
        applyStimulus("dnhi",  0, 1, MODE_DOWN, 0, 0, 0, 0, 1, 4'd13, 0, 0, 0, 0);
        applyStimulus("dn9",   0, 1, MODE_DOWN, 0, 0, 0, 0, 1, 4'd9, 0, 0, 0, 0);
        applyStimulus("dnld0", 0, 1, MODE_LOAD, 0, 0, 4'd0, 0, 1, 4'd8, 0, 0, 0, 0);
        applyStimulus("dn0",   0, 1, MODE_DOWN, 0, 0, 0, 0, 1, 4'd0, 1, 0, 0, 0);
        applyStimulus("dnwrap",0, 1, MODE_HOLD, 0, 0, 0, 0, 1, 4'd9, 0, 1, 0, 0);

        applyStimulus("prio9",  0, 1, MODE_UP,   0, 0, 0, 1, 1, 4'd9, 1, 1, 0, 0);
        applyStimulus("prio0",  0, 1, MODE_UP,   0, 0, 0, 1, 1, 4'd0, 0, 1, 0, 0);
        applyStimulus("prioclr",0, 1, MODE_HOLD, 0, 0, 0, 0, 1, 4'd1, 0, 0, 0, 0);

        applyStimulus("enld",  0, 1, MODE_LOAD, 0, 0, 4'd9, 0, 1, 4'd1, 0, 0, 0, 0);
        applyStimulus("en0a",  0, 0, MODE_UP,   0, 0, 0, 0, 1, 4'd9, 0, 0, 0, 0);
        applyStimulus("en0b",  0, 0, MODE_UP,   0, 0, 0, 0, 1, 4'd9, 0, 0, 0, 0);
        applyStimulus("rsvd",  0, 1, 3'b111,    4'hF, 4'h0, 4'h3, 0, 1, 4'd9, 0, 0, 0, 0);
        applyStimulus("rsvdq", 0, 1, MODE_HOLD, 0, 0, 0, 0, 1, 4'd9, 0, 0, 0, 0);

        applyStimulus("midrst", 1, 1, MODE_UP,   0, 0, 0, 0, 1, 4'd9, 1, 0, 0, 0);
        applyStimulus("resume", 0, 1, MODE_UP,   0, 0, 0, 0, 1, 4'd0, 0, 0, 1, 5);
        applyStimulus("after",  0, 1, MODE_HOLD, 0, 0, 0, 0, 1, 4'd1, 0, 0, 1, 6);

        for (int n = 0; n < 5 && sb.size() > 0; n++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/jk_mode_counter.md
Name: jk_mode_counter

Overview:
- Parametrised WIDTH-bit register built from per-bit JK cells; the successor to the single JK flip-flop.
- Modes: raw per-bit JK control, modulo up-count, modulo down-count, parallel load and hold.
- Adds terminal-count and sticky overflow status.
- Used as a general counter/timer/flag-register element in the digital logic designs.

Parameters:
- WIDTH, 4, register width in bits (1..16).
- MODULUS, 16, count modulus; legal range 2..2^WIDTH; counting wraps between 0 and MODULUS-1.
- RST_VAL, 0, value of q after reset; must be < MODULUS.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  operation enable; when low, state holds whatever mode is.
- mode  in  3  operation select (see Behaviour).
- j  in  WIDTH  per-bit J inputs (JK mode only).
- k  in  WIDTH  per-bit K inputs (JK mode only).
- d  in  WIDTH  parallel load data (LOAD mode only).
- clr_ovf  in  1  clears the sticky ovf flag.
- q  out  WIDTH  register state.
- tc  out  1  terminal count, combinational.
- ovf  out  1  sticky wrap flag, registered.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset:
  - rst=1 at a clock edge gives q=RST_VAL and ovf=0.
  - rst has priority over en, mode and clr_ovf.
  - Reset asserted mid-count takes effect at that edge; counting resumes from RST_VAL on the first edge after rst falls.
- Modes, acting only when en=1; en=0 holds q.
  - 000 HOLD: q unchanged.
  - 001 JK: each bit i independently follows its JK pair.
    - j=0,k=0: hold.
    - j=0,k=1: clear.
    - j=1,k=0: set.
    - j=1,k=1: toggle.
    - The JK result is not range-limited; q may exceed MODULUS-1.
  - 010 UP:
    - q < MODULUS-1: q+1.
    - q >= MODULUS-1: q=0 (wrap).
  - 011 DOWN:
    - 0 < q < MODULUS: q-1.
    - q=0: q=MODULUS-1 (wrap).
    - q >= MODULUS: q=MODULUS-1 (re-entry into range; this is not a wrap).
  - 100 LOAD: q=d, stored unmodified even if d >= MODULUS.
  - 101, 110, 111: reserved; behave as HOLD.
- Latency: q updates one edge after the qualifying inputs; there is no pipelining.
- Implementation: next-state logic computes target nxt for each bit. That bit's JK cell is driven with J = ~q & nxt and K = q & ~nxt, so the registered state is always produced by JK cells.
- Arithmetic: all comparisons are unsigned at WIDTH bits. When MODULUS = 2^WIDTH, the wrap is the natural overflow.
- tc = en & ((mode==UP & q>=MODULUS-1) | (mode==DOWN & q==0)). tc is high in exactly the cycle before a wrap edge.
- ovf:
  - Set at an edge where tc=1 (and rst=0).
  - Cleared at an edge where clr_ovf=1 and tc=0.
  - If set and clear occur on the same edge, set wins.
  - Otherwise ovf holds.

Decomposition:
- Shared package jk_pkg holds:
  - mode width constant (3).
  - Mode constants MODE_HOLD, MODE_JK, MODE_UP, MODE_DOWN, MODE_LOAD.
  - JK action encodings (HOLD/RESET/SET/TOGGLE) reused by future JK-based blocks.
- One sub-module: jk_cell, a single-bit JK flip-flop with synchronous active-high reset value input. It is instantiated WIDTH times via generate.
- Mode decode, next-state, tc and ovf logic live in the top level.

Test Plan:
- Reset: RST_VAL=0, rst=1 for 2 edges then 0, en=1, mode=HOLD -> q=0, ovf=0, tc=0. Set RST_VAL=5: assert rst while in UP at q=9 -> q=5 on that edge.
- JK mode, WIDTH=4, q=4'b1010, j=4'b0011, k=4'b0101:
  - Bit3: j=0,k=0, hold gives 1.
  - Bit2: j=0,k=1, clear gives 0.
  - Bit1: j=1,k=0, set gives 1.
  - Bit0: j=1,k=1, toggle gives 1.
  - Required result after one edge: q=4'b1011.
- UP with MODULUS=10: from q=0, 12 edges -> sequence 0..9,0,1,2. tc=1 only while q=9. ovf rises on the 9->0 edge and stays 1.
- DOWN with MODULUS=10: LOAD d=13, then DOWN -> q=9 with tc=0 and no ovf. Continue from q=0 -> q=9 with tc=1 beforehand and ovf set.
- ovf priority: ovf=1, q=9, UP, clr_ovf=1 -> ovf stays 1 (set wins). Next edge at q=0 with clr_ovf=1 -> ovf=0.
- en=0 with mode=UP at q=9 -> q holds 9, tc=0, ovf unchanged. Mode 3'b111 with en=1 -> q holds.
